// File: rtl/mem_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_req_ctrl                                                  |
// | Purpose  : Valid/ready request front end for a single-port synchronous   |
// |            RAM, with a credit-protected response FIFO that captures the  |
// |            RAM's one-cycle read data so nothing is lost under stall.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  // Credit level carries one extra bit so occ + rd_pend never overflows.
  localparam logic [CNT_W:0]   c_depth = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  rd_pend_q, rd_pend_d;

  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W:0]        w_level;

  // Handshakes, credit check and zero-latency RAM pin drive.
  always_comb begin
    rsp_valid = !reset && (occ_q != '0);
    rsp_rdata = fifo_q[rd_ptr_q];
    w_pop     = rsp_valid && rsp_ready;
    w_push    = rd_pend_q;
    // Entries already owed = buffered + in flight, minus the one leaving now.
    w_level   = {1'b0, occ_q} + {{CNT_W{1'b0}}, rd_pend_q} - {{CNT_W{1'b0}}, w_pop};
    req_ready = !reset && (w_level < c_depth);
    w_acc     = req_valid && req_ready;
    mem_we    = w_acc && req_we;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
  end

  // Next state: track the in-flight read, capture RAM data, advance pointers.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    rd_pend_d = w_acc && !req_we;
    if (w_push) begin
      fifo_d[wr_ptr_q] = mem_rdata;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State register; reset drops any in-flight read and all buffered data.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Capturing into a full buffer would drop read data; credits must prevent it.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (occ_q == c_full)));

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_req_ctrl                                               |
// | Purpose  : Self-checking bench for mem_req_ctrl with a RAM model and a   |
// |            transaction-level reference of responses and credits.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_req_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam logic [DW-1:0] c_step = 32'h01010101;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port RAM: read-before-write, cleared by the shared reset.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference: every accepted read is owed one response, visible 2 cycles later.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] ref_mem [256];
  int            cyc = 0;
  logic          e_ready, e_valid, e_we, e_acc, e_pop;
  logic [DW-1:0] e_rdata;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic setup(input logic rst, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    reset = rst; req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    e_valid = !rst && (q.size() > 0) && (cyc >= q[0].cyc + 2);
    e_rdata = e_valid ? q[0].data : '0;
    e_pop   = e_valid && rr;
    e_ready = !rst && ((q.size() - (e_pop ? 1 : 0)) < D);
    e_acc   = v && e_ready;
    e_we    = e_acc && we;
  endtask

  task automatic commit();
    rsp_t r;
    @(posedge clk);
    if (reset) begin
      q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else begin
          r.data = ref_mem[req_addr];
          r.cyc  = cyc;
          q.push_back(r);
        end
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    int t0;
    int first_v = -1;
    int nv = 0;
    for (int i = 0; i < 300; i++) begin
      setup(1'b1, 1'b1, 1'b1, 8'h55, 32'h1234, 1'b1);
      n_chk++; if (req_ready !== e_ready) $display("FAIL reset_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); else n_pass++;
      n_chk++; if (rsp_valid !== e_valid) $display("FAIL reset_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); else n_pass++;
      n_chk++; if (mem_we !== e_we) $display("FAIL reset_mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, e_we); else n_pass++;
      commit();
    end
    setup(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b1);
    n_chk++; if (req_ready !== 1'b1) $display("FAIL first_ready got=%b exp=1", req_ready); else n_pass++;
    t0 = cyc;
    commit();
    setup(1'b0, 1'b1, 1'b0, 8'hFF, '0, 1'b1);
    n_chk++; if (req_ready !== e_ready) $display("FAIL reset_rd2_ready got=%b exp=%b", req_ready, e_ready); else n_pass++;
    commit();
    for (int i = 0; i < 5; i++) begin
      setup(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      n_chk++; if (rsp_valid !== e_valid) $display("FAIL post_reset_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); else n_pass++;
      if (rsp_valid) begin
        if (first_v < 0) first_v = cyc;
        nv++;
        n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL post_reset_data got=%h exp=00000000", rsp_rdata); else n_pass++;
      end
      commit();
    end
    n_chk++; if (first_v - t0 !== 2) $display("FAIL reset_read_latency got=%0d exp=2", first_v - t0); else n_pass++;
    n_chk++; if (nv !== 2) $display("FAIL reset_rsp_count got=%0d exp=2", nv); else n_pass++;
  endtask

  task automatic test_write_read();
    int ta;
    int seen = 0;
    setup(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1);
    n_chk++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we got=%b exp=1", mem_we); else n_pass++;
    commit();
    setup(1'b0, 1'b1, 1'b0, 8'h10, 32'hFFFF0000, 1'b1);
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we got=%b exp=0", mem_we); else n_pass++;
    ta = cyc;
    commit();
    for (int i = 0; i < 4; i++) begin
      setup(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      n_chk++; if (mem_we !== 1'b0) $display("FAIL idle_mem_we got=%b exp=0", mem_we); else n_pass++;
      n_chk++; if (rsp_valid !== (cyc == ta + 2)) $display("FAIL raw_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, cyc == ta + 2); else n_pass++;
      if (rsp_valid) begin
        seen++;
        n_chk++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL raw_data got=%h exp=deadbeef", rsp_rdata); else n_pass++;
      end
      commit();
    end
    n_chk++; if (seen !== 1) $display("FAIL raw_rsp_count got=%0d exp=1", seen); else n_pass++;
  endtask

  task automatic test_streaming();
    int n_rsp = 0;
    int first_v = -1;
    int last_v = -1;
    for (int i = 0; i < 8; i++) begin
      setup(1'b0, 1'b1, 1'b1, AW'(i), c_step * DW'(i), 1'b1);
      n_chk++; if (req_ready !== 1'b1) $display("FAIL stream_wr_ready i=%0d got=%b exp=1", i, req_ready); else n_pass++;
      commit();
    end
    for (int i = 0; i < 12; i++) begin
      setup(1'b0, i < 8, 1'b0, AW'(i), '0, 1'b1);
      if (i < 8) begin
        n_chk++; if (req_ready !== 1'b1) $display("FAIL stream_rd_ready i=%0d got=%b exp=1", i, req_ready); else n_pass++;
      end
      if (rsp_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        n_chk++; if (rsp_rdata !== c_step * DW'(n_rsp)) $display("FAIL stream_data n=%0d got=%h exp=%h", n_rsp, rsp_rdata, c_step * DW'(n_rsp)); else n_pass++;
        n_rsp++;
      end
      commit();
    end
    n_chk++; if (n_rsp !== 8) $display("FAIL stream_count got=%0d exp=8", n_rsp); else n_pass++;
    n_chk++; if (last_v - first_v !== 7) $display("FAIL stream_consecutive got=%0d exp=7", last_v - first_v); else n_pass++;
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int n_pop = 0;
    for (int i = 0; i < 6; i++) begin
      setup(1'b0, 1'b1, 1'b0, AW'(n_acc), '0, 1'b0);
      n_chk++; if (req_ready !== e_ready) $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); else n_pass++;
      if (req_valid && req_ready) n_acc++;
      commit();
    end
    n_chk++; if (n_acc !== D) $display("FAIL bp_accepted got=%0d exp=%0d", n_acc, D); else n_pass++;
    for (int i = 0; i < 30 && (n_pop < 4); i++) begin
      setup(1'b0, n_acc < 4, 1'b0, AW'(n_acc), '0, 1'b1);
      n_chk++; if (req_ready !== e_ready) $display("FAIL bp_drain_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); else n_pass++;
      if (req_valid && req_ready) n_acc++;
      if (rsp_valid && rsp_ready) begin
        n_chk++; if (rsp_rdata !== c_step * DW'(n_pop)) $display("FAIL bp_data n=%0d got=%h exp=%h", n_pop, rsp_rdata, c_step * DW'(n_pop)); else n_pass++;
        n_pop++;
      end
      commit();
    end
    n_chk++; if (n_pop !== 4) $display("FAIL bp_delivered got=%0d exp=4", n_pop); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      setup(1'b0, ($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom % 16),
            DW'($urandom), ($urandom % 3) != 0);
      n_chk++; if (req_ready !== e_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); else n_pass++;
      n_chk++; if (rsp_valid !== e_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); else n_pass++;
      n_chk++; if (mem_we !== e_we) $display("FAIL rnd_mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, e_we); else n_pass++;
      if (e_valid) begin
        n_chk++; if (rsp_rdata !== e_rdata) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e_rdata); else n_pass++;
      end
      commit();
    end
    for (int i = 0; i < 4; i++) begin
      setup(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      setup(1'b0, i < 10, 1'b0, AW'($urandom % 16), '0, 1'b1);
      n_chk++; if (rsp_valid !== e_valid) $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_valid); else n_pass++;
      if (i < 10) begin
        n_chk++; if (req_ready !== 1'b1) $display("FAIL b2b_ready cyc=%0d got=%b exp=1", cyc, req_ready); else n_pass++;
      end
      if (e_valid) begin
        n_chk++; if (rsp_rdata !== e_rdata) $display("FAIL b2b_data cyc=%0d got=%h exp=%h", cyc, rsp_rdata, e_rdata); else n_pass++;
      end
      commit();
    end
  endtask

  task automatic test_mid_reset();
    int nv = 0;
    setup(1'b0, 1'b1, 1'b1, 8'h30, 32'hA5A5A5A5, 1'b0);
    commit();
    setup(1'b0, 1'b1, 1'b0, 8'h30, '0, 1'b0);
    commit();
    for (int i = 0; i < 2; i++) begin
      setup(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      commit();
    end
    setup(1'b0, 1'b1, 1'b0, 8'h30, '0, 1'b0);
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL mid_occ1_valid got=%b exp=1", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL mid_rd_ready got=%b exp=1", req_ready); else n_pass++;
    commit();
    setup(1'b1, 1'b1, 1'b1, 8'h30, 32'h1, 1'b1);
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", req_ready); else n_pass++;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL mid_rst_mem_we got=%b exp=0", mem_we); else n_pass++;
    commit();
    for (int i = 0; i < 3; i++) begin
      setup(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
      n_chk++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale_valid i=%0d got=%b exp=0", i, rsp_valid); else n_pass++;
      commit();
    end
    for (int i = 0; i < 6; i++) begin
      setup(1'b0, i < 2, 1'b0, 8'h30, '0, 1'b1);
      if (rsp_valid) begin
        nv++;
        n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL mid_post_data got=%h exp=00000000", rsp_rdata); else n_pass++;
      end
      commit();
    end
    n_chk++; if (nv !== 2) $display("FAIL mid_post_count got=%0d exp=2", nv); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request/response front end that sits directly upstream of the single-port synchronous RAM (`memory`) and drives its `we`/`addr`/`wdata` pins. It converts a valid/ready request stream into RAM accesses and captures the RAM's one-cycle, single-cycle-valid `rdata` into a response FIFO. The FIFO exposes read data on a valid/ready response stream with backpressure. It guarantees that no read data is lost when the consumer stalls.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width. Must match the RAM instance.
- `DATA_WIDTH`, default 32: data width. Must match the RAM instance.
- `RSP_DEPTH`, default 2: response FIFO entries. Minimum 2, power of 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. The same net also resets the RAM.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data. Ignored for reads.
- `rsp_valid`  out  1  read response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  DATA_WIDTH  read data, in request order.
- `mem_we`  out  1  to RAM `we`.
- `mem_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `mem_wdata`  out  DATA_WIDTH  to RAM `wdata`.
- `mem_rdata`  in  DATA_WIDTH  from RAM `rdata`.

## Operation
- **Accept.** `acc = req_valid && req_ready`.
- **Memory-side drive (combinational, zero added latency):**
  - `mem_we = acc && req_we`.
  - `mem_addr = req_addr`.
  - `mem_wdata = req_wdata`.
- **RAM read semantics.** `mem_rdata` in cycle t+1 equals the pre-write content of the address driven in cycle t. It is valid for that one cycle only.
- **In-flight flag.** `rd_pend` is a register set to `acc && !req_we` each cycle.
- **Capture.** When `rd_pend` = 1, `mem_rdata` is pushed into the FIFO at the end of that cycle.
- **Response FIFO.**
  - Circular buffer of RSP_DEPTH entries with wr_ptr, rd_ptr and occupancy count `occ` (0..RSP_DEPTH).
  - `rsp_valid = (occ != 0)`.
  - `rsp_rdata` = the head entry.
  - Pop when `rsp_valid && rsp_ready`.
- **Credit rule.**
  - `req_ready = !reset && (occ + rd_pend - pop) < RSP_DEPTH`.
  - `req_ready` does not depend on `req_we`, so writes are also stalled when credits are exhausted.
  - There is a combinational path from `rsp_ready` to `req_ready`; it is intentional.
- **Simultaneous push and pop.** `occ` is unchanged and both pointers advance.
- **Pointer wrap.** Pointers wrap modulo RSP_DEPTH.
- **Overflow/underflow.** Push when full is impossible by construction; flag it as an assertion. Pop when empty is ignored.
- **Write responses.** Writes generate no response.
- **Read-after-write, same address.** A read accepted the cycle after a write returns the new data. A read and write cannot be accepted together (single port).
- **Reset (including mid-operation):**
  - `occ`, pointers and `rd_pend` clear to 0.
  - Any in-flight read and all buffered data are discarded.
  - Outputs during reset: `req_ready=0`, `mem_we=0`, `rsp_valid=0`.

## Timing
- Read accepted in cycle t: RAM samples in t, `mem_rdata` is valid in t+1, captured at the end of t+1, and `rsp_valid`=1 from t+2. Read latency is 2 cycles.
- Write accepted in cycle t: RAM is updated at the end of t.
- Throughput is 1 request/cycle while `rsp_ready`=1 continuously (RSP_DEPTH ≥ 2).
- With `rsp_ready`=0, at most RSP_DEPTH reads are accepted. `req_ready` then stays 0 until a pop occurs.
- First cycle after reset deasserts: `req_ready`=1.

## Test plan
- **Reset clear.** Hold reset 300 cycles, release, read addr 0x00 and 0xFF. Required: `rsp_rdata`=0x00000000 both, at t+2 each; `rsp_valid`=0 and `req_ready`=0 throughout reset.
- **Write/read ordering.** Write 0xDEADBEEF @0x10, then read @0x10 the next cycle. Required: response 0xDEADBEEF, exactly 2 cycles after read accept; `mem_we` high only in the write cycle.
- **Streaming.** Write @0..7 with data = addr*0x01010101, then 8 back-to-back reads with `rsp_ready`=1. Required: `req_ready` never drops; 8 in-order responses 0x00000000..0x07070707 on consecutive cycles.
- **Backpressure.** `rsp_ready`=0, offer 4 reads. Required: exactly RSP_DEPTH (2) accepted and `req_ready`=0 afterwards. Raise `rsp_ready`. Required: both responses delivered in order, and the remaining reads accepted with no data lost or duplicated.
- **Simultaneous events.** With `occ`=1, pop and capture in the same cycle. Required: `occ` stays 1 and the pointers wrap correctly over 10 iterations.
- **Mid-operation reset.** Assert reset 1 cycle after a read accept with `occ`=1. Required: next cycle `rsp_valid`=0 and the stale data is never presented; reads after reset return 0.
